seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 4-digit seven-segment display bus: samples the anode-select and segment lines and rebuilds the four displayed digit codes plus decimal points.
- Used as an on-board display readback/self-check block and as a bench monitor alongside the calculator top level.
- Emits one frame at a time once all four digit positions have been seen stable.

Parameters:
- SETTLE_CYCLES, 4, consecutive clock cycles anode_in and seg_in must hold unchanged before a digit is captured (1..255).
- TIMEOUT_CYCLES, 200000, clock cycles without a completed frame before stale asserts (32-bit counter).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- anode_in  input  4  active-low digit enable; bit0 = digit0 (rightmost, ones) .. bit3 = digit3
- seg_in  input  8  active-low segments; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp
- digits  output  16  latched frame; [3:0]=digit0 .. [15:12]=digit3
- dp  output  4  latched decimal points, 1 = lit, bit n = digit n
- frame_valid  output  1  one-cycle pulse when digits/dp update
- stale  output  1  no frame completed within TIMEOUT_CYCLES
- err_count  output  8  invalid-pattern count (see Optional Feature)

Behaviour:
- Reset values: digits=16'hFFFF, dp=0, frame_valid=0, stale=0, err_count=0; FSM to IDLE, captured mask=0, counters=0.
- Segment decode on seg_in[7:1] (active-low), dp handled separately: 0..9 per standard a-g patterns (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100) -> 0..9; only g lit (1111110) -> 10 (minus); all off -> 15 (blank); anything else -> 14 (invalid).
- dp bit = ~seg_in[0].
- FSM IDLE: anode_in not exactly one low bit -> stay. One-hot-low -> snapshot anode_in/seg_in, counter=1, go SETTLE.
- FSM SETTLE: inputs equal snapshot -> counter++. Counter reaches SETTLE_CYCLES -> write decoded code and dp into shadow slot n, set mask[n], go HOLD.
  - Any change -> re-snapshot: one-hot stays in SETTLE with counter=1; otherwise go IDLE.
- FSM HOLD: wait until anode_in differs from snapshot, then evaluate as IDLE in the same cycle.
  - Segment change with same anode is ignored: one capture per anode dwell.
- Recapture of an already-set slot overwrites the shadow; mask unchanged.
- Frame completion: cycle after mask reaches 4'b1111, copy shadow to digits/dp, pulse frame_valid for one cycle, clear mask.
  - Scan order is irrelevant.
- Timeout counter: increments every cycle and clears on frame_valid. stale=1 when it reaches TIMEOUT_CYCLES; counter saturates there. stale clears on the next frame_valid.
- Reset mid-frame discards the shadow and mask; no frame_valid is produced from pre-reset captures.
- Latency: from anode assertion to capture is SETTLE_CYCLES cycles; frame_valid follows the fourth capture by 1 cycle.

Optional Feature:
- Macro SEGDEC_ERRCNT_EN.
- Defined: err_count increments (saturating at 255) on each capture that decodes to 14. Also increments once per IDLE/SETTLE exit caused by a multi-low anode_in. Clears only on reset.
- Undefined: err_count is constant 0 and no counter logic is synthesized; all other behaviour is identical.

Test Plan:
- Scan digits 4,3,2,1 (anode 1110/1101/1011/0111, 10 cycles each, SETTLE_CYCLES=4) -> single frame_valid pulse, digits=16'h1234 read as digit3..0 = 1,2,3,4, dp=0.
- Digit2 shows minus (seg_in=8'b11111101), others blank (8'hFF) -> digits=16'hFAFF.
- Digit1 shows 5 with dp (8'b01001000) -> digit1=5, dp=4'b0010.
- Anode glitch of 3 cycles on digit0 -> no capture and no frame; glitch extended to 4 cycles -> capture occurs.
- seg_in=8'b10101011 on digit3, plus anode_in=4'b1100 for 6 cycles -> digit3=14. With SEGDEC_ERRCNT_EN, err_count=2; without it, err_count=0.
- Assert reset after 3 digits captured, then scan all 4 -> exactly one frame_valid, after the 4th post-reset capture. Hold anode_in=4'hF for TIMEOUT_CYCLES (set to 50) -> stale=1; next frame -> stale=0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan bus receiver: rebuilds the four digit codes and decimal points from anode/segment lines.
// Optional invalid-pattern counter enabled by defining SEGDEC_ERRCNT_EN.
module seg_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  anode_in,
   input  logic [7:0]  seg_in,
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic        frame_valid,
   output logic        stale,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_HOLD = 2'd2} state_t;

   localparam logic [8:0]  LP_SETTLE = 9'(SETTLE_CYCLES);
   localparam logic [31:0] LP_TMO    = 32'(TIMEOUT_CYCLES);
   localparam bit          LP_ONE    = (SETTLE_CYCLES <= 1);

   function automatic logic [3:0] f_decode(input logic [6:0] seg);
      logic [3:0] code;
      case (seg)
         7'b0000001: code = 4'd0;
         7'b1001111: code = 4'd1;
         7'b0010010: code = 4'd2;
         7'b0000110: code = 4'd3;
         7'b1001100: code = 4'd4;
         7'b0100100: code = 4'd5;
         7'b0100000: code = 4'd6;
         7'b0001111: code = 4'd7;
         7'b0000000: code = 4'd8;
         7'b0000100: code = 4'd9;
         7'b1111110: code = 4'hA;
         7'b1111111: code = 4'hF;
         default:    code = 4'hE;
      endcase
      return code;
   endfunction

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_snap_an;
   logic [7:0]  r_snap_seg;
   logic [7:0]  r_cnt;
   logic [3:0]  r_mask;
   logic [15:0] r_shadow_dig;
   logic [3:0]  r_shadow_dp;
   logic [15:0] r_digits;
   logic [3:0]  r_dp;
   logic        r_fv;
   logic [31:0] r_to_cnt;

   logic [3:0]  w_an_lo;
   logic        w_onehot;
   logic        w_same;
   logic        w_an_chg;
   logic        w_eval;
   logic        w_done;
   logic        w_snap;
   logic        w_cap;
   logic        w_cnt_inc;
   logic        w_frame;
   logic [1:0]  w_slot;
   logic [3:0]  w_code;

   assign w_an_lo  = ~anode_in;
   assign w_onehot = (w_an_lo != 4'd0) && ((w_an_lo & (w_an_lo - 4'd1)) == 4'd0);
   assign w_same   = (anode_in == r_snap_an) && (seg_in == r_snap_seg);
   assign w_an_chg = (anode_in != r_snap_an);
   assign w_code   = f_decode(seg_in[7:1]);
   assign w_frame  = (r_mask == 4'hF);

   // HOLD re-evaluates like IDLE as soon as the anode moves; a SETTLE disturbance does the same
   assign w_eval = (r_state == S_IDLE) ||
                   ((r_state == S_SETTLE) && !w_same) ||
                   ((r_state == S_HOLD) && w_an_chg);
   assign w_done = (r_state == S_SETTLE) && w_same && ((9'(r_cnt) + 9'd1) >= LP_SETTLE);

   always_comb begin
      w_slot = 2'd0;
      case (w_an_lo)
         4'b0010: w_slot = 2'd1;
         4'b0100: w_slot = 2'd2;
         4'b1000: w_slot = 2'd3;
         default: w_slot = 2'd0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_SETTLE, S_HOLD: begin
            if (w_eval)      w_next_state = !w_onehot ? S_IDLE : (LP_ONE ? S_HOLD : S_SETTLE);
            else if (w_done) w_next_state = S_HOLD;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_snap    = w_eval && w_onehot;
      w_cap     = w_done || (w_snap && LP_ONE);
      w_cnt_inc = (r_state == S_SETTLE) && w_same && !w_done;
   end

   always_ff @(posedge clock) begin
      if (w_snap) begin
         r_snap_an  <= anode_in;
         r_snap_seg <= seg_in;
      end
      if (w_cap) begin
         r_shadow_dig[w_slot*4 +: 4] <= w_code;
         r_shadow_dp[w_slot]         <= ~seg_in[0];
      end
   end

   // Frame publish runs one cycle after the mask fills; a capture in that cycle starts the next frame
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt    <= 8'd0;
         r_mask   <= 4'd0;
         r_digits <= 16'hFFFF;
         r_dp     <= 4'd0;
         r_fv     <= 1'b0;
         r_to_cnt <= 32'd0;
      end else begin
         if (w_snap)         r_cnt <= 8'd1;
         else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
         r_mask <= (w_frame ? 4'd0 : r_mask) | (w_cap ? w_an_lo : 4'd0);
         r_fv   <= w_frame;
         if (w_frame) begin
            r_digits <= r_shadow_dig;
            r_dp     <= r_shadow_dp;
         end
         if (w_frame)                r_to_cnt <= 32'd0;
         else if (r_to_cnt != LP_TMO) r_to_cnt <= r_to_cnt + 32'd1;
      end
   end

   assign digits      = r_digits;
   assign dp          = r_dp;
   assign frame_valid = r_fv;
   assign stale       = (r_to_cnt == LP_TMO);

`ifdef SEGDEC_ERRCNT_EN
   logic       w_multi;
   logic       w_err_inc;
   logic       r_multi_prev;
   logic [7:0] r_err;

   // A multi-low anode episode counts once, not once per cycle it persists
   assign w_multi   = ((w_an_lo & (w_an_lo - 4'd1)) != 4'd0);
   assign w_err_inc = (w_cap && (w_code == 4'hE)) || (w_multi && !r_multi_prev);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_multi_prev <= 1'b0;
         r_err        <= 8'd0;
      end else begin
         r_multi_prev <= w_multi;
         if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      end
   end

   assign err_count = r_err;
`else
   assign err_count = 8'h00;
`endif

endmodule
